sdf_twiddle_gen: RTL and testbench



---
 rtl/sdf_twiddle_gen.sv | 167 ++++++++++++++++
 tb/tb_sdf_twiddle_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_twiddle_gen.sv
// Twiddle-factor sequencer for one radix-2^2 SDF stage pair.
// Emits W_M^e = cos(2*pi*e/M) - j*sin(2*pi*e/M) in signed Q1.(WIDTH-1) for every
// valid sample leaving BF2II, two cycles after the sample's in_valid. Coefficients
// come from a quarter-wave cosine table (M/4+1 entries) folded over three quadrants.
module sdf_twiddle_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned M     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sync,
  output logic                    out_valid,
  output logic                    out_sync,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  localparam int unsigned NB = $clog2(M);  // sample index bits
  localparam int unsigned RB = NB - 2;     // bits of r = n mod M/4
  localparam int unsigned Q  = M / 4;
  localparam int unsigned IB = NB - 1;     // table index bits, covers 0..M/4

  // round(cos(2*pi*f/M) * (2^(WIDTH-1)-1)); f <= M/4 keeps the result non-negative,
  // so no table entry can be the most negative code and every negation is exact.
  function automatic logic signed [WIDTH-1:0] cos_entry(input int unsigned f);
    real amp;
    real x;
    amp = real'((2 ** (WIDTH - 1)) - 1);
    x   = $cos(2.0 * 3.14159265358979323846 * real'(f) / real'(M)) * amp;
    if (x < 0.0) begin
      x = 0.0;
    end
    return WIDTH'($rtoi(x + 0.5));
  endfunction

  logic signed [WIDTH-1:0] rom [Q+1];

  for (genvar g = 0; g < Q + 1; g++) begin : g_rom
    localparam logic signed [WIDTH-1:0] Entry = cos_entry(g);
    assign rom[g] = Entry;
  end

  // ---------------------------------------------------------------------------
  // Sample counter
  // ---------------------------------------------------------------------------
  logic [NB-1:0] cnt_q;
  logic [NB-1:0] idx;

  // A sync restarts the frame on the current sample.
  always_comb begin
    idx = in_sync ? '0 : cnt_q;
  end

  // Counter advances on every valid sample; wraps naturally since M is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (in_valid) begin
      cnt_q <= idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Exponent e = r * k(q), k = {0, 2, 1, 3}, built from shifts and adds
  // ---------------------------------------------------------------------------
  logic [1:0]    quad;
  logic [RB-1:0] r;
  logic [NB-1:0] r_ext;
  logic [NB-1:0] e;
  logic [1:0]    p;
  logic [RB-1:0] f;
  logic [IB-1:0] f_ext;
  logic [IB-1:0] qmf;

  // Index split, exponent and quadrant fold of e.
  always_comb begin
    quad  = idx[NB-1 -: 2];
    r     = idx[RB-1:0];
    r_ext = {2'b00, r};
    case (quad)
      2'd0:    e = '0;
      2'd1:    e = r_ext << 1;
      2'd2:    e = r_ext;
      default: e = (r_ext << 1) + r_ext;
    endcase
    // e < 3M/4, so p only ever takes 0..2.
    p     = e[NB-1 -: 2];
    f     = e[RB-1:0];
    f_ext = {1'b0, f};
    qmf   = IB'(Q) - f_ext;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: quadrant, fold offsets and qualifiers
  // ---------------------------------------------------------------------------
  logic          s1_valid_q;
  logic          s1_sync_q;
  logic [1:0]    s1_p_q;
  logic [IB-1:0] s1_f_q;
  logic [IB-1:0] s1_qmf_q;

  // Register the decoded lookup addresses; sync only travels with a valid sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sync_q  <= 1'b0;
      s1_p_q     <= '0;
      s1_f_q     <= '0;
      s1_qmf_q   <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_sync_q  <= in_valid & in_sync;
      if (in_valid) begin
        s1_p_q   <= p;
        s1_f_q   <= f_ext;
        s1_qmf_q <= qmf;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: table lookup and sign selection
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] c_f;
  logic signed [WIDTH-1:0] c_qmf;
  logic signed [WIDTH-1:0] re_d;
  logic signed [WIDTH-1:0] im_d;

  // Quadrant symmetry: sin(2*pi*f/M) is read as C[M/4-f].
  always_comb begin
    c_f   = rom[s1_f_q];
    c_qmf = rom[s1_qmf_q];
    case (s1_p_q)
      2'd1: begin
        re_d = -c_qmf;
        im_d = -c_f;
      end
      2'd2: begin
        re_d = -c_f;
        im_d = c_qmf;
      end
      default: begin
        re_d = c_f;
        im_d = -c_qmf;
      end
    endcase
  end

  // Output registers; coefficients hold their last value while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= s1_valid_q;
      out_sync  <= s1_valid_q & s1_sync_q;
      if (s1_valid_q) begin
        out_re <= re_d;
        out_im <= im_d;
      end
    end
  end

endmodule

// File: tb/tb_sdf_twiddle_gen.sv
// Randomised self-checking bench for sdf_twiddle_gen. Two instances share the
// stimulus: WIDTH=8/M=16 (exact compare) and WIDTH=12/M=64 (+-1 LSB compare).
module tb_sdf_twiddle_gen;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_sync;

  logic              a_valid, a_sync;
  logic signed [7:0] a_re, a_im;
  logic              b_valid, b_sync;
  logic signed [11:0] b_re, b_im;

  sdf_twiddle_gen #(.WIDTH(8), .M(16)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .out_valid(a_valid),
    .out_sync (a_sync),
    .out_re   (a_re),
    .out_im   (a_im)
  );

  sdf_twiddle_gen #(.WIDTH(12), .M(64)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .out_valid(b_valid),
    .out_sync (b_sync),
    .out_re   (b_re),
    .out_im   (b_im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    bit sync;
    int cyc;
    int n;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   ref_na, ref_nb;
  exp_t qa[$];
  exp_t qb[$];
  int   last_re_a, last_im_a;
  bit   cap_en;
  int   cap_re [16];
  int   cap_im [16];

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    int d;
    n_cmp++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
    end
  endtask

  function automatic int kmap(int q);
    case (q)
      0:       return 0;
      1:       return 2;
      2:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int rnd(real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  // Reference: W_M^e with e = (n mod M/4) * k(n div M/4), scaled by A = 2^(W-1)-1.
  function automatic exp_t model(int idx, int m, int amp, bit s, int c);
    exp_t x;
    int   e;
    real  ang;
    e      = (idx % (m / 4)) * kmap(idx / (m / 4));
    ang    = 2.0 * 3.14159265358979323846 * real'(e) / real'(m);
    x.re   = rnd(real'(amp) * $cos(ang));
    x.im   = rnd(-real'(amp) * $sin(ang));
    x.sync = s;
    x.cyc  = c;
    x.n    = idx;
    return x;
  endfunction

  task automatic observe();
    exp_t ea, eb;
    if (a_valid) begin
      if (qa.size() == 0) begin
        check("a_spurious_valid", 1, 0);
      end else begin
        ea = qa.pop_front();
        check("a_latency", cyc - ea.cyc, 2);
        check("a_re", a_re, ea.re);
        check("a_im", a_im, ea.im);
        check("a_sync", a_sync, ea.sync);
        last_re_a = ea.re;
        last_im_a = ea.im;
        if (cap_en) begin
          cap_re[ea.n] = a_re;
          cap_im[ea.n] = a_im;
        end
      end
    end else begin
      check("a_hold_re", a_re, last_re_a);
      check("a_hold_im", a_im, last_im_a);
      check("a_sync_idle", a_sync, 0);
    end
    if (qa.size() != 0 && cyc - qa[0].cyc > 2) begin
      check("a_missing_valid", cyc - qa[0].cyc, 2);
      void'(qa.pop_front());
    end

    if (b_valid) begin
      if (qb.size() == 0) begin
        check("b_spurious_valid", 1, 0);
      end else begin
        eb = qb.pop_front();
        check("b_latency", cyc - eb.cyc, 2);
        check("b_re", b_re, eb.re, 1);
        check("b_im", b_im, eb.im, 1);
        check("b_sync", b_sync, eb.sync);
        check("b_re_not_min", (int'(b_re) == -2048) ? 1 : 0, 0);
        check("b_im_not_min", (int'(b_im) == -2048) ? 1 : 0, 0);
      end
    end
    if (qb.size() != 0 && cyc - qb[0].cyc > 2) begin
      check("b_missing_valid", cyc - qb[0].cyc, 2);
      void'(qb.pop_front());
    end
  endtask

  // Drive one cycle of input (called just after a rising edge), then observe.
  task automatic tick(input bit v, input bit s);
    int ia, ib;
    in_valid = v;
    in_sync  = s;
    if (v && rst_n) begin
      ia     = s ? 0 : ref_na;
      ref_na = (ia + 1) % 16;
      ib     = s ? 0 : ref_nb;
      ref_nb = (ib + 1) % 64;
      qa.push_back(model(ia, 16, 127, s, cyc));
      qb.push_back(model(ib, 64, 2047, s, cyc));
    end
    @(posedge clk);
    #1;
    cyc++;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    observe();
  endtask

  task automatic drain();
    repeat (4) tick(1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_a_valid", a_valid, 0);
    check("rst_a_sync", a_sync, 0);
    check("rst_a_re", a_re, 0);
    check("rst_a_im", a_im, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_b_re", b_re, 0);
    check("rst_b_im", b_im, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sync   = 1'b0;
    ref_na    = 0;
    ref_nb    = 0;
    last_re_a = 0;
    last_im_a = 0;
    cap_en    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cap_re[i] = 999;
      cap_im[i] = 999;
    end
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Contiguous frame with sync on the first sample.
    cap_en = 1'b1;
    tick(1'b1, 1'b1);
    for (int i = 1; i < 16; i++) tick(1'b1, 1'b0);
    drain();
    cap_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("tbl_re_n0to4", cap_re[i], 127);
      check("tbl_im_n0to4", cap_im[i], 0);
    end
    check("tbl_re_n5", cap_re[5], 90);
    check("tbl_im_n5", cap_im[5], -90);
    check("tbl_re_n9", cap_re[9], 117);
    check("tbl_im_n9", cap_im[9], -49);
    check("tbl_re_n7", cap_re[7], -90);
    check("tbl_im_n7", cap_im[7], -90);
    check("tbl_re_n15", cap_re[15], -117);
    check("tbl_im_n15", cap_im[15], 49);

    // Same frame with random 0..3-cycle gaps.
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, i == 0);
      repeat ($urandom_range(0, 3)) tick(1'b0, 1'b0);
    end
    drain();

    // Three back-to-back frames, sync only on the first.
    tick(1'b1, 1'b1);
    for (int i = 1; i < 48; i++) tick(1'b1, 1'b0);
    drain();

    // Mid-frame sync at n=6.
    tick(1'b1, 1'b1);
    for (int i = 1; i < 6; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    drain();

    // Asynchronous reset with samples in flight (n=10 just taken).
    tick(1'b1, 1'b1);
    for (int i = 1; i <= 10; i++) tick(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    qa.delete();
    qb.delete();
    ref_na    = 0;
    ref_nb    = 0;
    last_re_a = 0;
    last_im_a = 0;
    tick(1'b1, 1'b0);  // edge while reset is still low: sample ignored
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0);
    drain();

    // Full M=64 frame for the wide instance, plus a wrap.
    tick(1'b1, 1'b1);
    for (int i = 1; i < 74; i++) tick(1'b1, 1'b0);
    drain();

    // Random traffic with occasional syncs.
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    drain();

    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
